mc_control_unit_v2: RTL and testbench

//  Multicycle MIPS-subset control FSM, successor to the first-generation controller. Decodes the IR

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_alu_decode.sv | 30 +++
 rtl/mc_control_unit_v2.sv | 171 +++++++++++++++++
 tb/tb_mc_control_unit_v2.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_BRANCH   = 4'd5,
    S_JUMP     = 4'd6,
    S_JR       = 4'd7,
    S_JAL      = 4'd8,
    S_MEM_ADDR = 4'd9,
    S_MEM_RD   = 4'd10,
    S_MEM_WB   = 4'd11,
    S_MEM_WR   = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // Opcode dispatch taken at the end of DECODE.
  function automatic state_e dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_e nxt;
    unique case (op)
      OP_RTYPE:        nxt = (fn == FN_JR) ? S_JR : S_EXEC_R;
      OP_J:            nxt = S_JUMP;
      OP_JAL:          nxt = S_JAL;
      OP_BEQ, OP_BNE:  nxt = S_BRANCH;
      OP_ADDI, OP_ANDI: nxt = S_EXEC_I;
      OP_LW, OP_SW:    nxt = S_MEM_ADDR;
      default:         nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU-operation decode from opcode/funct; flags R-type funct
// codes the ALU does not implement.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       illegal_funct_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_op_o        = ALU_ADD;
    illegal_funct_o = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      unique case (funct_i)
        FN_ADD:  alu_op_o = ALU_ADD;
        FN_SUB:  alu_op_o = ALU_SUB;
        FN_AND:  alu_op_o = ALU_AND;
        FN_OR:   alu_op_o = ALU_OR;
        FN_SLT:  alu_op_o = ALU_SLT;
        default: illegal_funct_o = 1'b1;
      endcase
    end else if (opcode_i == OP_ANDI) begin
      alu_op_o = ALU_AND;
    end
  end

endmodule

// File: rtl/mc_control_unit_v2.sv
// Multicycle MIPS-subset control FSM: one state per cycle, memory handshake
// stalls, internal beq/bne resolution, jr/jal and an illegal-opcode trap.
module mc_control_unit_v2
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_WAIT_EN = 1,
  parameter int TRAP_HALT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               wr_reg_ra,
  output logic               mem_to_reg,
  output logic               wr_data_pc,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               pc_en,
  output logic               illegal_op,
  output logic [3:0]         state_o
);

  state_e     state_q, state_d;
  logic [5:0] opcode, funct;
  logic       mem_ok;
  logic [2:0] dec_alu_op;
  logic       dec_illegal_funct;
  logic [2:0] alu_op_s;
  logic       unused_instr_bits;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];
  assign mem_ok            = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  mc_alu_decode u_alu_decode (
    .opcode_i        (opcode),
    .funct_i         (funct),
    .alu_op_o        (dec_alu_op),
    .illegal_funct_o (dec_illegal_funct)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    wr_reg_ra     = 1'b0;
    mem_to_reg    = 1'b0;
    wr_data_pc    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    alu_op_s      = ALU_AND;
    illegal_op    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op_s  = ALU_ADD;
        // IR load and PC+4 happen only on the cycle the read completes.
        if (mem_ok) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op_s  = ALU_ADD;
        state_d   = dispatch(opcode, funct);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op_s  = dec_alu_op;
        state_d   = dec_illegal_funct ? S_TRAP : S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op_s  = dec_alu_op;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_RTYPE);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op_s      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        pc_src   = PCSRC_REGA;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        wr_reg_ra  = 1'b1;
        wr_data_pc = 1'b1;
        reg_write  = 1'b1;
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op_s  = ALU_ADD;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ok) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
        state_d    = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign alu_op  = ALUOP_W'(alu_op_s);
  assign pc_en   = pc_write | (pc_write_cond & (zero ^ (opcode == OP_BNE)));
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_unit_v2.sv
// Directed bench for mc_control_unit_v2: per-cycle vector table plus hand
// sequences for trap, bad funct and reset during a stalled store.
module tb_mc_control_unit_v2;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero, mem_ready;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst;
  logic wr_reg_ra, mem_to_reg, wr_data_pc, reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  logic [20:0] act_ctl;

  mc_control_unit_v2 dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .wr_reg_ra(wr_reg_ra), .mem_to_reg(mem_to_reg),
    .wr_data_pc(wr_data_pc), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .pc_en(pc_en),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign act_ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    reg_dst, wr_reg_ra, mem_to_reg, wr_data_pc, reg_write, alu_src_a,
                    alu_src_b, pc_src, alu_op, pc_en, illegal_op};

  // Bit positions within act_ctl.
  localparam logic [20:0] PCW = 21'h100000, PWC = 21'h080000, IORD = 21'h040000;
  localparam logic [20:0] MR  = 21'h020000, MW  = 21'h010000, IRW  = 21'h008000;
  localparam logic [20:0] RD  = 21'h004000, WRA = 21'h002000, MTR  = 21'h001000;
  localparam logic [20:0] WDP = 21'h000800, RW  = 21'h000400, SA   = 21'h000200;
  localparam logic [20:0] PEN = 21'h000002, ILL = 21'h000001;
  localparam logic [20:0] SB4 = 21'd1 << 7, SBI = 21'd2 << 7, SBS = 21'd3 << 7;
  localparam logic [20:0] PS_J = 21'd1 << 5, PS_AO = 21'd2 << 5, PS_A = 21'd3 << 5;
  localparam logic [20:0] A_AND = 21'd0, A_OR = 21'd1 << 2, A_ADD = 21'd2 << 2;
  localparam logic [20:0] A_SUB = 21'd6 << 2, A_SLT = 21'd7 << 2;

  localparam logic [20:0] F1  = PCW | MR | IRW | SB4 | A_ADD | PEN;
  localparam logic [20:0] F0  = MR | SB4 | A_ADD;
  localparam logic [20:0] DE  = SBS | A_ADD;
  localparam logic [20:0] WBR = RW | RD;
  localparam logic [20:0] WBI = RW;
  localparam logic [20:0] BRT = SA | A_SUB | PWC | PS_AO | PEN;
  localparam logic [20:0] BRN = SA | A_SUB | PWC | PS_AO;
  localparam logic [20:0] JP  = PCW | PS_J | PEN;
  localparam logic [20:0] JRC = PCW | PS_A | PEN;
  localparam logic [20:0] JL  = WRA | WDP | RW | PCW | PS_J | PEN;
  localparam logic [20:0] MA  = SA | SBI | A_ADD;
  localparam logic [20:0] MRD = IORD | MR;
  localparam logic [20:0] MWB = RW | MTR;
  localparam logic [20:0] MWR = IORD | MW;
  localparam logic [20:0] TRP = ILL;

  localparam logic [31:0] ADD_I  = 32'h00221820, SUB_I = 32'h00221822;
  localparam logic [31:0] AND_I  = 32'h00221824, OR_I  = 32'h00221825;
  localparam logic [31:0] SLT_I  = 32'h0022182A, JR_I  = 32'h03E00008;
  localparam logic [31:0] ADDI_I = 32'h20220005, ANDI_I = 32'h30220005;
  localparam logic [31:0] BEQ_I  = 32'h10220004, BNE_I = 32'h14220004;
  localparam logic [31:0] J_I    = 32'h08000010, JAL_I = 32'h0C000010;
  localparam logic [31:0] LW_I   = 32'h8C220004, SW_I  = 32'hAC220004;
  localparam logic [31:0] BADOP_I = 32'hFC000000, BADFN_I = 32'h0022183F;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    state_e      st;
    logic [20:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void row(input logic [31:0] i, input logic z, input logic r,
                              input state_e s, input logic [20:0] c);
    vec_t v;
    v.instr = i; v.zero = z; v.rdy = r; v.st = s; v.ctl = c;
    vecs.push_back(v);
  endfunction

  function automatic void seq_alu(input logic [31:0] i, input state_e xs,
                                  input logic [20:0] ex, input logic [20:0] wb);
    row(i, 1'b0, 1'b1, S_FETCH, F1);
    row(i, 1'b0, 1'b1, S_DECODE, DE);
    row(i, 1'b0, 1'b1, xs, ex);
    row(i, 1'b0, 1'b1, S_ALU_WB, wb);
  endfunction

  function automatic void seq3(input logic [31:0] i, input logic z, input state_e s,
                               input logic [20:0] c);
    row(i, z, 1'b1, S_FETCH, F1);
    row(i, z, 1'b1, S_DECODE, DE);
    row(i, z, 1'b1, s, c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, compare mid-low-phase.
  task automatic step(input string tag, input logic [31:0] i, input logic z, input logic r,
                      input state_e s, input logic [20:0] c);
    instr = i; zero = z; mem_ready = r;
    #1;
    check({tag, " state"}, 32'(state_o), 32'(s));
    check({tag, " ctl"}, 32'(act_ctl), 32'(c));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, " state"}, 32'(state_o), 32'(S_FETCH));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    seq_alu(ADD_I, S_EXEC_R, SA | A_ADD, WBR);
    seq_alu(SUB_I, S_EXEC_R, SA | A_SUB, WBR);
    seq_alu(AND_I, S_EXEC_R, SA | A_AND, WBR);
    seq_alu(OR_I,  S_EXEC_R, SA | A_OR,  WBR);
    seq_alu(SLT_I, S_EXEC_R, SA | A_SLT, WBR);
    seq_alu(ADDI_I, S_EXEC_I, SA | SBI | A_ADD, WBI);
    seq_alu(ANDI_I, S_EXEC_I, SA | SBI | A_AND, WBI);
    seq3(BEQ_I, 1'b1, S_BRANCH, BRT);
    seq3(BEQ_I, 1'b0, S_BRANCH, BRN);
    seq3(BNE_I, 1'b1, S_BRANCH, BRN);
    seq3(BNE_I, 1'b0, S_BRANCH, BRT);
    seq3(J_I,   1'b0, S_JUMP, JP);
    seq3(JR_I,  1'b0, S_JR,   JRC);
    seq3(JAL_I, 1'b0, S_JAL,  JL);
    // lw and sw, no stalls
    row(LW_I, 1'b0, 1'b1, S_FETCH, F1);    row(LW_I, 1'b0, 1'b1, S_DECODE, DE);
    row(LW_I, 1'b0, 1'b1, S_MEM_ADDR, MA); row(LW_I, 1'b0, 1'b1, S_MEM_RD, MRD);
    row(LW_I, 1'b0, 1'b1, S_MEM_WB, MWB);
    row(SW_I, 1'b0, 1'b1, S_FETCH, F1);    row(SW_I, 1'b0, 1'b1, S_DECODE, DE);
    row(SW_I, 1'b0, 1'b1, S_MEM_ADDR, MA); row(SW_I, 1'b0, 1'b1, S_MEM_WR, MWR);
    // lw stalled three cycles in MEM_RD; mem_ready ignored outside memory states
    row(LW_I, 1'b0, 1'b1, S_FETCH, F1);    row(LW_I, 1'b0, 1'b0, S_DECODE, DE);
    row(LW_I, 1'b0, 1'b0, S_MEM_ADDR, MA);
    for (int k = 0; k < 3; k++) row(LW_I, 1'b0, 1'b0, S_MEM_RD, MRD);
    row(LW_I, 1'b0, 1'b1, S_MEM_RD, MRD);  row(LW_I, 1'b0, 1'b0, S_MEM_WB, MWB);
    // fetch stalled two cycles, single ir/pc write on the third
    row(J_I, 1'b0, 1'b0, S_FETCH, F0);     row(J_I, 1'b0, 1'b0, S_FETCH, F0);
    row(J_I, 1'b0, 1'b1, S_FETCH, F1);     row(J_I, 1'b0, 1'b1, S_DECODE, DE);
    row(J_I, 1'b0, 1'b1, S_JUMP, JP);
    // sw stalled one cycle
    row(SW_I, 1'b0, 1'b1, S_FETCH, F1);    row(SW_I, 1'b0, 1'b1, S_DECODE, DE);
    row(SW_I, 1'b0, 1'b1, S_MEM_ADDR, MA); row(SW_I, 1'b0, 1'b0, S_MEM_WR, MWR);
    row(SW_I, 1'b0, 1'b1, S_MEM_WR, MWR);  row(ADD_I, 1'b0, 1'b1, S_FETCH, F1);

    rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    check("reset state", 32'(state_o), 32'(S_FETCH));
    check("reset mem_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      step($sformatf("vec%0d", k), vecs[k].instr, vecs[k].zero, vecs[k].rdy,
           vecs[k].st, vecs[k].ctl);

    // Illegal opcode parks in TRAP.
    do_reset("rst_a");
    step("ill_f", BADOP_I, 1'b0, 1'b1, S_FETCH, F1);
    step("ill_d", BADOP_I, 1'b0, 1'b1, S_DECODE, DE);
    for (int k = 0; k < 3; k++) step($sformatf("ill_trap%0d", k), BADOP_I, 1'b0, 1'b1, S_TRAP, TRP);

    // Unknown R-type funct traps after EXEC_R; reset leaves TRAP.
    do_reset("rst_b");
    step("fn_f", BADFN_I, 1'b0, 1'b1, S_FETCH, F1);
    step("fn_d", BADFN_I, 1'b0, 1'b1, S_DECODE, DE);
    #1;
    check("fn_exec state", 32'(state_o), 32'(S_EXEC_R));
    @(negedge clk);
    step("fn_trap", BADFN_I, 1'b0, 1'b1, S_TRAP, TRP);

    // Reset asserted mid-cycle during a stalled store.
    do_reset("rst_c");
    step("sw_f", SW_I, 1'b0, 1'b1, S_FETCH, F1);
    step("sw_d", SW_I, 1'b0, 1'b1, S_DECODE, DE);
    step("sw_ma", SW_I, 1'b0, 1'b1, S_MEM_ADDR, MA);
    instr = SW_I; mem_ready = 1'b0;
    #1;
    check("sw_wr state", 32'(state_o), 32'(S_MEM_WR));
    check("sw_wr mem_write", 32'(mem_write), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("sw_rst state", 32'(state_o), 32'(S_FETCH));
    check("sw_rst mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step("post_f0", SW_I, 1'b0, 1'b0, S_FETCH, F0);
    step("post_f1", SW_I, 1'b0, 1'b1, S_FETCH, F1);
    step("post_d", SW_I, 1'b0, 1'b1, S_DECODE, DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
